// File: rtl/score_keeper.sv
// score_keeper -- rhythm-game scoring block.
//
// Purpose: tracks the score as four BCD digits (saturating at 9999), the
// current and best combo, and a timed display of the last judgment. Game flow
// is IDLE -> PLAY -> DONE. A start pulse (re)starts a game from any state and
// clears all of the game's outputs.
//
// Optional feature: define SCORE_KEEPER_COMBO_BONUS_EN to double a perfect
// hit's points (3 -> 6) while the combo before that hit is at least 10.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   pulse: begin or restart a game
//   stop         in   pulse: end the game
//   judge_valid  in   pulse: hit event
//   judge_grade  in   [1:0] 11 perfect, 10 late, 01 early, 00 none
//   miss         in   pulse: note left the hit window unhit
//   score_bcd    out  [15:0] four BCD digits, most significant in [15:12]
//   combo        out  [7:0] consecutive hits
//   max_combo    out  [7:0] best combo this game
//   grade_disp   out  [1:0] last judgment, cleared after DISP_CYCLES
//   playing      out  high in PLAY
//   game_over    out  one-cycle pulse on entry to DONE
module score_keeper #(
  parameter logic [23:0] DISP_CYCLES = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        judge_valid,
  input  logic [1:0]  judge_grade,
  input  logic        miss,
  output logic [15:0] score_bcd,
  output logic [7:0]  combo,
  output logic [7:0]  max_combo,
  output logic [1:0]  grade_disp,
  output logic        playing,
  output logic        game_over
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [15:0] score_reg;
  logic [7:0]  combo_reg;
  logic [7:0]  max_combo_reg;
  logic [1:0]  grade_reg;
  logic [23:0] timer_reg;
  logic        game_over_reg;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  // start wins over stop, so a simultaneous start/stop in PLAY restarts.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = PLAY;
      PLAY:    if (start) state_next = PLAY;
               else if (stop) state_next = DONE;
      DONE:    if (start) state_next = PLAY;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    playing = (state_reg == PLAY);
  end

  always_ff @(posedge clk) begin
    if (rst) game_over_reg <= 1'b0;
    else     game_over_reg <= (state_reg == PLAY) && (state_next == DONE);
  end

  // ---------------- judgment decode ----------------
  logic       hit;
  logic       miss_event;
  logic [3:0] points;

  // A valid judgment with grade 00 counts as a miss.
  assign hit        = judge_valid && (judge_grade != 2'b00);
  assign miss_event = miss || (judge_valid && (judge_grade == 2'b00));

  always_comb begin
    points = 4'd0;
    if (hit) begin
      if (judge_grade == 2'b11) begin
`ifdef SCORE_KEEPER_COMBO_BONUS_EN
        points = (combo_reg >= 8'd10) ? 4'd6 : 4'd3;
`else
        points = 4'd3;
`endif
      end else begin
        points = 4'd1;
      end
    end
  end

  // ---------------- BCD adder: score + points ----------------
  // Ripple through the four digits; a carry out of the top digit means the
  // true sum exceeds 9999, so the result pins at 9999.
  logic [4:1]  carry;
  logic [15:0] score_sum;
  logic [15:0] score_add;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_bcd
      logic [4:0] raw;
      if (gi == 0) begin : g_lsd
        assign raw = {1'b0, score_reg[3:0]} + {1'b0, points};
      end else begin : g_upper
        assign raw = {1'b0, score_reg[gi*4 +: 4]} + {4'd0, carry[gi]};
      end
      assign carry[gi+1]          = (raw > 5'd9);
      assign score_sum[gi*4 +: 4] = carry[gi+1] ? 4'(raw - 5'd10) : raw[3:0];
    end
  endgenerate

  assign score_add = carry[4] ? 16'h9999 : score_sum;

  logic [7:0] combo_inc;
  assign combo_inc = (combo_reg == 8'hFF) ? combo_reg : combo_reg + 8'd1;

  // ---------------- score / combo / display registers ----------------
  always_ff @(posedge clk) begin
    if (rst || start) begin
      score_reg     <= 16'h0000;
      combo_reg     <= 8'd0;
      max_combo_reg <= 8'd0;
      grade_reg     <= 2'b00;
      timer_reg     <= 24'd0;
    end else if (state_reg == PLAY) begin
      if (hit) begin
        score_reg <= score_add;
        // A simultaneous miss still lets the hit count toward max_combo.
        combo_reg <= miss_event ? 8'd0 : combo_inc;
        if (combo_inc > max_combo_reg) max_combo_reg <= combo_inc;
      end else if (miss_event) begin
        combo_reg <= 8'd0;
      end

      if (judge_valid || miss) begin
        grade_reg <= judge_valid ? judge_grade : 2'b00;
        timer_reg <= DISP_CYCLES;
      end else if (timer_reg != 24'd0) begin
        timer_reg <= timer_reg - 24'd1;
        if (timer_reg == 24'd1) grade_reg <= 2'b00;
      end
    end
  end

  assign score_bcd  = score_reg;
  assign combo      = combo_reg;
  assign max_combo  = max_combo_reg;
  assign grade_disp = grade_reg;
  assign game_over  = game_over_reg;

endmodule

// File: tb/tb_score_keeper.sv
// Testbench for score_keeper: a directed vector table, hand-written corner
// sequences and a randomized run, all checked every cycle against a
// decimal-arithmetic reference model.
module tb_score_keeper;

  localparam logic [23:0] DISP = 24'd20;

  logic        clk = 1'b0;
  logic        rst = 1'b0, start = 1'b0, stop = 1'b0, judge_valid = 1'b0, miss = 1'b0;
  logic [1:0]  judge_grade = 2'b00;
  logic [15:0] score_bcd;
  logic [7:0]  combo, max_combo;
  logic [1:0]  grade_disp;
  logic        playing, game_over;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  score_keeper #(.DISP_CYCLES(DISP)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .judge_valid(judge_valid), .judge_grade(judge_grade), .miss(miss),
    .score_bcd(score_bcd), .combo(combo), .max_combo(max_combo),
    .grade_disp(grade_disp), .playing(playing), .game_over(game_over)
  );

  // ---------------- reference model (plain decimal arithmetic) ----------------
  int m_mode  = 0;   // 0 idle, 1 play, 2 done
  int m_score = 0;
  int m_combo = 0;
  int m_max   = 0;
  int m_grade = 0;
  int m_timer = 0;
  bit m_go    = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_step(input logic r, input logic s, input logic p,
                            input logic jv, input logic [1:0] jg, input logic m);
    int pts;
    bit go_n;
    if (r) begin
      m_mode = 0; m_score = 0; m_combo = 0; m_max = 0;
      m_grade = 0; m_timer = 0; m_go = 1'b0;
    end else begin
      go_n = (m_mode == 1) && p && !s;
      if (s) begin
        m_mode = 1; m_score = 0; m_combo = 0; m_max = 0; m_grade = 0; m_timer = 0;
      end else if (m_mode == 1) begin
        if (jv && jg != 2'b00) begin
          pts = (jg == 2'b11) ? 3 : 1;
`ifdef SCORE_KEEPER_COMBO_BONUS_EN
          if (jg == 2'b11 && m_combo >= 10) pts = 6;
`endif
          m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
          m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
          if (m_combo > m_max) m_max = m_combo;
        end
        if (m || (jv && jg == 2'b00)) m_combo = 0;
        if (jv || m) begin
          m_grade = jv ? int'(jg) : 0;
          m_timer = int'(DISP);
        end else if (m_timer > 0) begin
          m_timer--;
          if (m_timer == 0) m_grade = 0;
        end
        if (p) m_mode = 2;
      end
      m_go = go_n;
    end
  endtask

  // ---------------- drive one cycle, compare against model ----------------
  task automatic tick(input logic r, input logic s, input logic p,
                      input logic jv, input logic [1:0] jg, input logic m);
    logic [35:0] exp_v, act_v;
    rst = r; start = s; stop = p; judge_valid = jv; judge_grade = jg; miss = m;
    model_step(r, s, p, jv, jg, m);
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; stop = 1'b0; judge_valid = 1'b0; judge_grade = 2'b00; miss = 1'b0;
    exp_v = {to_bcd(m_score), 8'(m_combo), 8'(m_max), 2'(m_grade), (m_mode == 1), m_go};
    act_v = {score_bcd, combo, max_combo, grade_disp, playing, game_over};
    total++;
    if (act_v !== exp_v) begin
      bad++;
      $display("FAIL model t=%0t got score=%h combo=%0d max=%0d grade=%b play=%b go=%b want score=%h combo=%0d max=%0d grade=%b play=%b go=%b",
               $time, act_v[35:20], act_v[19:12], act_v[11:4], act_v[3:2], act_v[1], act_v[0],
               exp_v[35:20], exp_v[19:12], exp_v[11:4], exp_v[3:2], exp_v[1], exp_v[0]);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic idle();            tick(0, 0, 0, 0, 2'b00, 0); endtask
  task automatic hit(input logic [1:0] g); tick(0, 0, 0, 1, g, 0); endtask
  task automatic do_start();        tick(0, 1, 0, 0, 2'b00, 0); endtask
  task automatic do_miss();         tick(0, 0, 0, 0, 2'b00, 1); endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic        r, s, p, jv;
    logic [1:0]  jg;
    logic        m;
    logic [15:0] sc;
    logic [7:0]  cb, mx;
    logic [1:0]  gd;
    logic        pl, go;
  } vec_t;

  vec_t tbl [20];

  initial begin
    // inputs: r s p jv jg m | expected: score combo max grade playing game_over
    tbl[0]  = '{1,0,0,0,2'b00,0, 16'h0000, 8'd0, 8'd0, 2'b00, 0, 0}; // reset
    tbl[1]  = '{0,0,0,1,2'b11,0, 16'h0000, 8'd0, 8'd0, 2'b00, 0, 0}; // idle ignores hit
    tbl[2]  = '{0,1,0,0,2'b00,0, 16'h0000, 8'd0, 8'd0, 2'b00, 1, 0}; // start
    tbl[3]  = '{0,0,0,1,2'b11,0, 16'h0003, 8'd1, 8'd1, 2'b11, 1, 0};
    tbl[4]  = '{0,0,0,1,2'b11,0, 16'h0006, 8'd2, 8'd2, 2'b11, 1, 0};
    tbl[5]  = '{0,0,0,1,2'b11,0, 16'h0009, 8'd3, 8'd3, 2'b11, 1, 0};
    tbl[6]  = '{0,0,0,1,2'b11,0, 16'h0012, 8'd4, 8'd4, 2'b11, 1, 0}; // 4 perfects
    tbl[7]  = '{0,0,0,1,2'b10,0, 16'h0013, 8'd5, 8'd5, 2'b10, 1, 0}; // late
    tbl[8]  = '{0,0,0,1,2'b01,0, 16'h0014, 8'd6, 8'd6, 2'b01, 1, 0}; // early
    tbl[9]  = '{0,0,0,0,2'b00,1, 16'h0014, 8'd0, 8'd6, 2'b00, 1, 0}; // miss
    tbl[10] = '{0,0,0,1,2'b00,0, 16'h0014, 8'd0, 8'd6, 2'b00, 1, 0}; // grade 00 = miss
    tbl[11] = '{0,0,0,1,2'b11,0, 16'h0017, 8'd1, 8'd6, 2'b11, 1, 0};
    tbl[12] = '{0,0,1,0,2'b00,0, 16'h0017, 8'd1, 8'd6, 2'b11, 0, 1}; // stop
    tbl[13] = '{0,0,0,0,2'b00,0, 16'h0017, 8'd1, 8'd6, 2'b11, 0, 0}; // pulse ends
    tbl[14] = '{0,0,0,1,2'b11,0, 16'h0017, 8'd1, 8'd6, 2'b11, 0, 0}; // done ignores hit
    tbl[15] = '{0,0,0,0,2'b00,1, 16'h0017, 8'd1, 8'd6, 2'b11, 0, 0}; // done ignores miss
    tbl[16] = '{0,0,1,0,2'b00,0, 16'h0017, 8'd1, 8'd6, 2'b11, 0, 0}; // stop in done
    tbl[17] = '{0,1,0,0,2'b00,0, 16'h0000, 8'd0, 8'd0, 2'b00, 1, 0}; // restart clears
    tbl[18] = '{0,1,1,1,2'b11,0, 16'h0000, 8'd0, 8'd0, 2'b00, 1, 0}; // start beats stop
    tbl[19] = '{0,0,0,1,2'b11,0, 16'h0003, 8'd1, 8'd1, 2'b11, 1, 0};

    for (int i = 0; i < 20; i++) begin
      logic [35:0] want;
      tick(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].jv, tbl[i].jg, tbl[i].m);
      want = {tbl[i].sc, tbl[i].cb, tbl[i].mx, tbl[i].gd, tbl[i].pl, tbl[i].go};
      check($sformatf("vec%0d", i),
            32'({score_bcd, combo, max_combo, grade_disp, playing, game_over} ^ want), 32'd0);
    end

    // ---- BCD carry: 0x0098 + perfect -> 0x0101 ----
    do_start();
    repeat (98) hit(2'b10);
    do_miss();                      // drop combo so no bonus applies
    check("score_0098", 32'(score_bcd), 32'h0098);
    hit(2'b11);
    check("bcd_carry", 32'(score_bcd), 32'h0101);

    // ---- saturation and combo cap ----
    do_start();
    repeat (9998) hit(2'b10);
    check("score_9998", 32'(score_bcd), 32'h9998);
    check("combo_sat", 32'(combo), 32'd255);
    check("max_sat", 32'(max_combo), 32'd255);
    hit(2'b11);
    check("score_sat", 32'(score_bcd), 32'h9999);
    hit(2'b11);
    check("score_hold", 32'(score_bcd), 32'h9999);

    // ---- hit and miss in the same cycle ----
    do_start();
    repeat (5) hit(2'b11);
    check("combo5", 32'(combo), 32'd5);
    tick(0, 0, 0, 1, 2'b11, 1);
    check("both_score", 32'(score_bcd), 32'h0018);
    check("both_combo", 32'(combo), 32'd0);
    check("both_max", 32'(max_combo), 32'd6);
    check("both_grade", 32'(grade_disp), 32'd3);

    // ---- eleven perfects: bonus on the 11th only when enabled ----
    do_start();
    repeat (11) hit(2'b11);
`ifdef SCORE_KEEPER_COMBO_BONUS_EN
    check("eleven_perfect", 32'(score_bcd), 32'h0036);
`else
    check("eleven_perfect", 32'(score_bcd), 32'h0033);
`endif

    // ---- display timer ----
    do_start();
    hit(2'b11);
    repeat (19) idle();
    check("disp_hold", 32'(grade_disp), 32'd3);
    idle();
    check("disp_clear", 32'(grade_disp), 32'd0);
    hit(2'b11);
    repeat (10) idle();
    hit(2'b10);                     // restarts the timer
    repeat (19) idle();
    check("disp_restart", 32'(grade_disp), 32'd2);
    idle();
    check("disp_restart_clr", 32'(grade_disp), 32'd0);

    // ---- reset mid-game ----
    do_start();
    repeat (42) hit(2'b01);
    check("score_0042", 32'(score_bcd), 32'h0042);
    tick(1, 0, 0, 1, 2'b11, 0);
    check("rst_outputs", 32'({score_bcd, combo, max_combo, grade_disp, playing, game_over}), 32'd0);
    hit(2'b11);
    hit(2'b10);
    check("rst_ignore", 32'({score_bcd, combo, max_combo, grade_disp, playing}), 32'd0);
    do_start();
    check("rst_restart", 32'(playing), 32'd1);

    // ---- randomized run against the model ----
    for (int i = 0; i < 4000; i++) begin
      logic r, s, p, jv, m;
      logic [1:0] jg;
      r  = ($urandom_range(0, 299) == 0);
      s  = (m_mode != 1) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 149) == 0);
      p  = ($urandom_range(0, 119) == 0);
      jv = ($urandom_range(0, 2) == 0);
      jg = 2'($urandom_range(0, 3));
      m  = ($urandom_range(0, 5) == 0);
      tick(r, s, p, jv, jg, m);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
